// File: rtl/cram_wr_ctrl_pkg.sv
// rtl/cram_wr_ctrl_pkg.sv - shared types for the CRAM write controller
package cram_wr_ctrl_pkg;

  typedef logic [14:0] cram_word_t;
  typedef logic [7:0]  cram_addr_t;

  typedef struct packed {
    cram_addr_t addr;
    cram_word_t data;
  } fifo_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // CPU palette word: bit 7 of the high byte has no colour meaning and is dropped
  function automatic cram_word_t pack_word(input logic [6:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/cram_wr_fifo.sv
// rtl/cram_wr_fifo.sv - synchronous CPU word FIFO, power-of-two depth
module cram_wr_fifo
  import cram_wr_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fifo_entry_t              wr_entry_i,
  output fifo_entry_t              rd_entry_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  // A pop frees the slot before the push looks at fullness, so full+push+pop is accepted
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rd_entry_o = mem_q[rd_ptr_q];

  // Storage array needs no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cram_wr_ctrl.sv
// rtl/cram_wr_ctrl.sv - CPU/DMA palette write arbiter into CRAM; DMA path under CRAM_WR_DMA_EN
module cram_wr_ctrl
  import cram_wr_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c3,
  input  logic        cpu_wr,
  input  logic        cpu_a0,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        dma_start,
  input  logic [7:0]  dma_saddr,
  input  logic        dma_req,
  input  logic [14:0] dma_data,
  output logic        dma_ack,
  output logic [7:0]  cram_addr_in,
  output logic [14:0] cram_data_in,
  output logic        cram_we,
  output logic        fifo_full,
  output logic        ovf
);

  state_t       state_q, state_d;
  logic         cram_we_q, cram_we_d;
  logic         dma_ack_q, dma_ack_d;
  cram_addr_t   cram_addr_q, cram_addr_d;
  cram_word_t   cram_data_q, cram_data_d;
  logic [7:0]   lo_q;
  logic         push_pend_q;
  fifo_entry_t  push_entry_q;
  logic         ovf_q;

  logic         fifo_pop;
  logic         fifo_empty;
  fifo_entry_t  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic         dma_grant;
  logic         dma_req_eff;
  cram_addr_t   dma_addr_cur;
  cram_word_t   dma_word;

  logic         unused_bits;
  assign unused_bits = ^{cpu_data[7], fifo_count};

  cram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_pend_q),
    .pop_i      (fifo_pop),
    .wr_entry_i (push_entry_q),
    .rd_entry_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

`ifdef CRAM_WR_DMA_EN
  cram_addr_t dma_ptr_q;

  // A start pulse in the grant cycle redirects that very grant to the new address
  assign dma_req_eff  = dma_req;
  assign dma_addr_cur = dma_start ? dma_saddr : dma_ptr_q;
  assign dma_word     = dma_data;

  // DMA address pointer: advance after each granted word, reload on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_ptr_q <= '0;
    end else if (dma_grant) begin
      dma_ptr_q <= dma_addr_cur + 8'd1;
    end else if (dma_start) begin
      dma_ptr_q <= dma_saddr;
    end
  end
`else
  logic dma_unused;
  assign dma_unused   = ^{dma_start, dma_saddr, dma_req, dma_data, dma_grant};
  assign dma_req_eff  = 1'b0;
  assign dma_addr_cur = '0;
  assign dma_word     = '0;
`endif

  // CPU byte capture: low byte parks in lo_q, high byte queues a full word for the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q         <= '0;
      push_pend_q  <= 1'b0;
      push_entry_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      push_pend_q <= cpu_wr & cpu_a0;
      if (cpu_wr & cpu_a0) begin
        push_entry_q.addr <= cpu_addr;
        push_entry_q.data <= pack_word(cpu_data[6:0], lo_q);
      end
      if (cpu_wr & ~cpu_a0) lo_q <= cpu_data;
      if (push_pend_q & fifo_full & ~fifo_pop) ovf_q <= 1'b1;
    end
  end

  // Arbiter state and registered CRAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cram_we_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cram_addr_q <= '0;
      cram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cram_we_q   <= cram_we_d;
      dma_ack_q   <= dma_ack_d;
      cram_addr_q <= cram_addr_d;
      cram_data_q <= cram_data_d;
    end
  end

  // Decide on c3 from IDLE only: queued CPU words beat DMA, and WRITE always returns to IDLE
  always_comb begin
    state_d     = state_q;
    cram_we_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cram_addr_d = cram_addr_q;
    cram_data_d = cram_data_q;
    fifo_pop    = 1'b0;
    dma_grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c3) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            cram_addr_d = fifo_head.addr;
            cram_data_d = fifo_head.data;
            cram_we_d   = 1'b1;
            state_d     = ST_WRITE;
          end else if (dma_req_eff) begin
            dma_grant   = 1'b1;
            cram_addr_d = dma_addr_cur;
            cram_data_d = dma_word;
            cram_we_d   = 1'b1;
            dma_ack_d   = 1'b1;
            state_d     = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cram_we      = cram_we_q;
  assign dma_ack      = dma_ack_q;
  assign cram_addr_in = cram_addr_q;
  assign cram_data_in = cram_data_q;
  assign ovf          = ovf_q;

endmodule

// File: doc/cram_wr_ctrl.md
CRAM_WR_CTRL -- requirements
Module: cram_wr_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, CPU word FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port c3  in  1  write-slot strobe; CRAM writes issue only in cycles with c3=1.
REQ-005 SHALL have port cpu_wr  in  1  one-cycle CPU palette byte write strobe.
REQ-006 SHALL have port cpu_a0  in  1  byte select: 0=low byte, 1=high byte.
REQ-007 SHALL have port cpu_addr  in  8  palette entry index.
REQ-008 SHALL have port cpu_data  in  8  CPU write byte.
REQ-009 SHALL have port dma_start  in  1  one-cycle pulse loading DMA address.
REQ-010 SHALL have port dma_saddr  in  8  DMA start address.
REQ-011 SHALL have port dma_req  in  1  DMA word valid, held until dma_ack.
REQ-012 SHALL have port dma_data  in  15  DMA palette word.
REQ-013 SHALL have port dma_ack  out  1  one-cycle DMA word accepted.
REQ-014 SHALL have port cram_addr_in  out  8  CRAM write address.
REQ-015 SHALL have port cram_data_in  out  15  CRAM write data {R5,G5,B5}.
REQ-016 SHALL have port cram_we  out  1  CRAM write enable, one cycle per word.
REQ-017 SHALL have ports fifo_full, ovf  out  1 each  FIFO full; sticky overflow.

Function
REQ-018 cpu_wr with cpu_a0=0 SHALL latch cpu_data into lo_reg; no FIFO push.
REQ-019 cpu_wr with cpu_a0=1 SHALL push {cpu_data[6:0], lo_reg} with cpu_addr into FIFO next cycle; cpu_data[7] ignored.
REQ-020 High write while FIFO full SHALL be dropped and set ovf; ovf clears only on reset.
REQ-021 Push and pop in same cycle while full SHALL be accepted (pop first); no ovf.
REQ-022 Arbiter SHALL act only when c3=1: FIFO non-empty -> pop head to CRAM; else dma_req=1 -> write DMA word.
REQ-023 CRAM outputs SHALL be registered; cram_we asserted cycle after the c3 decision, deasserted otherwise; latency cpu_wr(hi) -> cram_we at most 2 cycles plus wait to next c3 when FIFO was empty.
REQ-024 DMA write SHALL use dma_ptr, pulse dma_ack in the cram_we cycle, then dma_ptr increments modulo 256 (255->0).
REQ-025 dma_start SHALL load dma_ptr=dma_saddr; same-cycle arbiter DMA grant SHALL use the new address.
REQ-026 State machine IDLE -> (c3 & work) -> WRITE -> IDLE; WRITE lasts exactly one cycle; no back-to-back writes without a new c3.
REQ-027 fifo_full SHALL equal count==FIFO_DEPTH combinationally from registered count.
REQ-028 lo_reg SHALL persist across multiple high writes (reuse allowed).

Reset
REQ-029 rst_n low SHALL clear cram_we, dma_ack, ovf, FIFO pointers/count, lo_reg, dma_ptr, cram_addr_in, cram_data_in to 0, state IDLE.
REQ-030 Reset mid-write SHALL abort; pending FIFO words lost; no cram_we after release until new c3 with work.

Configuration
REQ-031 Macro CRAM_WR_DMA_EN SHALL compile DMA path in; without it dma_ack ties 0, dma_* inputs ignored, dma_ptr absent, arbiter serves FIFO only.

Structure
REQ-032 Shared package SHALL hold cram_word_t (15-bit), cram_addr_t (8-bit), FIFO entry struct {addr, data}, state enum.
REQ-033 FIFO SHALL be a sub-module cram_wr_fifo (sync, parameterized depth, push/pop/full/empty/count).

Verification
REQ-034 lo=0x1F at 0x10, hi=0x7C -> one cram_we, addr 0x10, data 0x7C1F, on first c3.
REQ-035 Five hi writes, no c3, FIFO_DEPTH=4 -> fifo_full=1, fifth dropped, ovf=1; four writes later in order.
REQ-036 dma_start saddr=0xFE, three dma_req words -> writes at 0xFE, 0xFF, 0x00, three dma_ack pulses.
REQ-037 FIFO word and dma_req both pending at c3 -> FIFO word written first, DMA on next c3.
REQ-038 rst_n low during WRITE with 2 queued -> cram_we=0, FIFO empty, ovf=0; no writes after release.
REQ-039 Build without CRAM_WR_DMA_EN, dma_req=1 -> dma_ack stays 0, no DMA writes.
